fft_tw_agu: RTL and testbench

- Address and twiddle-index generator for the shared-butterfly radix-2 DIT in-place FFT.
- Walks all log2(N) stages × N/2 butterflies and issues the twiddle index k to the twiddle generator.
- Delays the butterfly operand addresses by the twiddle generator's latency, so addresses and twiddle arrive at the butterfly in the same cycle.
- Sits directly upstream of the twiddle generator and the data-RAM read port.

---
 rtl/fft_tw_agu.sv | 123 ++++++++++++
 tb/tb_fft_tw_agu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_tw_agu.sv
// fft_tw_agu: walks radix-2 DIT stages/butterflies, issues twiddle index k and operand addresses,
// and delays the addresses by TW_LAT so they meet the twiddle at the butterfly.
module fft_tw_agu #(
    parameter int N         = 8192,
    parameter int TW_LAT    = 2,
    parameter int STAGE_GAP = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         en,
    output logic                         busy,
    output logic [$clog2(N/2)-1:0]       k,
    output logic                         iss_valid,
    output logic [$clog2(N)-1:0]         iss_addr_a,
    output logic [$clog2(N)-1:0]         iss_addr_b,
    output logic                         bf_valid,
    output logic [$clog2(N)-1:0]         bf_addr_a,
    output logic [$clog2(N)-1:0]         bf_addr_b,
    output logic [$clog2($clog2(N)):0]   bf_stage,
    output logic                         bf_last,
    output logic                         done
);
    localparam int S  = $clog2(N);
    localparam int AW = S;
    localparam int KW = S - 1;
    localparam int SW = $clog2(S) + 1;
    localparam int GW = STAGE_GAP > 1 ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0] GAP_END = GW'(STAGE_GAP > 0 ? STAGE_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} state_t;
    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [SW-1:0] s;
        logic          l;
    } dl_t;

    state_t        state, state_nx;
    logic [SW-1:0] stg, stg_nx, iss_stg;
    logic [KW-1:0] b, b_nx, kc;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [AW-1:0] pos, addr_a, addr_b;
    logic          issue, last_b, last_s, gap_end, iss_last;
    dl_t           dl [TW_LAT];

    assign pos     = AW'(b) & ((AW'(1) << stg) - AW'(1));
    assign addr_a  = ((AW'(b) >> stg) << (stg + SW'(1))) | pos;
    assign addr_b  = addr_a + (AW'(1) << stg);
    assign kc      = KW'(pos << (S - 1 - stg));
    assign last_b  = b == KW'(N/2 - 1);
    assign last_s  = stg == SW'(S - 1);
    assign gap_end = gap_cnt == GAP_END;

    assign busy      = state != IDLE;
    assign bf_valid  = dl[TW_LAT-1].v;
    assign bf_addr_a = dl[TW_LAT-1].a;
    assign bf_addr_b = dl[TW_LAT-1].b;
    assign bf_stage  = dl[TW_LAT-1].s;
    assign bf_last   = dl[TW_LAT-1].l;
    // An earlier stage's last tag can still be in flight, so match the final stage too.
    assign done      = state == FLUSH && bf_last && bf_stage == SW'(S - 1);

    always_comb begin
        state_nx = state;
        stg_nx   = stg;
        b_nx     = b;
        gap_nx   = gap_cnt;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                state_nx = start ? RUN : IDLE;
                issue    = start & en;
            end
            RUN: issue = en;
            GAP: begin
                gap_nx   = gap_end ? '0 : gap_cnt + GW'(1);
                state_nx = gap_end ? RUN : GAP;
                stg_nx   = gap_end ? stg + SW'(1) : stg;
            end
            default: state_nx = done ? IDLE : FLUSH;
        endcase
        if (issue) begin
            b_nx = b + KW'(1);
            if (last_b) begin
                state_nx = last_s ? FLUSH : (STAGE_GAP > 0 ? GAP : RUN);
                stg_nx   = last_s ? '0 : (STAGE_GAP > 0 ? stg : stg + SW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            stg        <= '0;
            b          <= '0;
            gap_cnt    <= '0;
            iss_valid  <= 1'b0;
            iss_addr_a <= '0;
            iss_addr_b <= '0;
            k          <= '0;
            iss_stg    <= '0;
            iss_last   <= 1'b0;
            for (int i = 0; i < TW_LAT; i++) dl[i] <= '0;
        end else begin
            state     <= state_nx;
            stg       <= stg_nx;
            b         <= b_nx;
            gap_cnt   <= gap_nx;
            iss_valid <= issue;
            iss_last  <= issue & last_b;
            if (issue) begin
                iss_addr_a <= addr_a;
                iss_addr_b <= addr_b;
                k          <= kc;
                iss_stg    <= stg;
            end
            dl[0] <= {iss_valid, iss_addr_a, iss_addr_b, iss_stg, iss_last};
            for (int i = 1; i < TW_LAT; i++) dl[i] <= dl[i-1];
        end
    end
endmodule

// File: tb/tb_fft_tw_agu.sv
// tb_fft_tw_agu: directed checks of the N=8 walk (gap, stall, reset, start spam) and
// a full N=8192 random-enable run checking twiddle/address alignment.
module tb_fft_tw_agu;
    logic clk = 0, rst = 0, sel = 0, st = 0, en_r = 0, st2 = 0, en2 = 0;
    int checks = 0, errors = 0;

    logic       busy0, iv0, bv0, bl0, dn0, busy1, iv1, bv1, bl1, dn1;
    logic [1:0] k0, k1;
    logic [2:0] ia0, ib0, ba0, bb0, bs0, ia1, ib1, ba1, bb1, bs1;
    logic        busy2, iv2, bv2, bl2, dn2;
    logic [11:0] k2;
    logic [12:0] ia2, ib2, ba2, bb2;
    logic [4:0]  bs2;

    logic       m_busy, m_iv, m_bv, m_bl, m_dn;
    logic [1:0] m_k;
    logic [2:0] m_a, m_b, m_ba, m_bb, m_bs;

    always #5 clk = ~clk;

    fft_tw_agu #(.N(8), .TW_LAT(2), .STAGE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .start(st & !sel), .en(en_r & !sel), .busy(busy0), .k(k0),
        .iss_valid(iv0), .iss_addr_a(ia0), .iss_addr_b(ib0), .bf_valid(bv0), .bf_addr_a(ba0),
        .bf_addr_b(bb0), .bf_stage(bs0), .bf_last(bl0), .done(dn0));
    fft_tw_agu #(.N(8), .TW_LAT(2), .STAGE_GAP(3)) u1 (
        .clk(clk), .rst(rst), .start(st & sel), .en(en_r & sel), .busy(busy1), .k(k1),
        .iss_valid(iv1), .iss_addr_a(ia1), .iss_addr_b(ib1), .bf_valid(bv1), .bf_addr_a(ba1),
        .bf_addr_b(bb1), .bf_stage(bs1), .bf_last(bl1), .done(dn1));
    fft_tw_agu #(.N(8192), .TW_LAT(2), .STAGE_GAP(4)) u2 (
        .clk(clk), .rst(rst), .start(st2), .en(en2), .busy(busy2), .k(k2),
        .iss_valid(iv2), .iss_addr_a(ia2), .iss_addr_b(ib2), .bf_valid(bv2), .bf_addr_a(ba2),
        .bf_addr_b(bb2), .bf_stage(bs2), .bf_last(bl2), .done(dn2));

    assign m_busy = sel ? busy1 : busy0;
    assign m_iv   = sel ? iv1 : iv0;
    assign m_a    = sel ? ia1 : ia0;
    assign m_b    = sel ? ib1 : ib0;
    assign m_k    = sel ? k1 : k0;
    assign m_bv   = sel ? bv1 : bv0;
    assign m_ba   = sel ? ba1 : ba0;
    assign m_bb   = sel ? bb1 : bb0;
    assign m_bs   = sel ? bs1 : bs0;
    assign m_bl   = sel ? bl1 : bl0;
    assign m_dn   = sel ? dn1 : dn0;

    typedef struct {
        logic busy; logic iv; logic [2:0] a; logic [2:0] b; logic [1:0] k;
        logic bv; logic [2:0] ba; logic [2:0] bb; logic [2:0] bs; logic bl; logic dn;
    } rec_t;
    rec_t L [64];

    // Hand-derived N=8 butterfly order: stage 0, 1, 2 with four butterflies each.
    int ta [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tk [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input bit s, input int hs, input int hl, input bit spam, output int lc);
        for (int i = 0; i < 64; i++) L[i] = '{default: '0};
        sel = s; st = 1; en_r = 1; lc = 0;
        for (int c = 1; c < 64; c++) begin
            tick();
            L[c] = '{m_busy, m_iv, m_a, m_b, m_k, m_bv, m_ba, m_bb, m_bs, m_bl, m_dn};
            st = spam && (c % 3 == 0) && c <= 18;
            en_r = !(c >= hs && c < hs + hl);
            lc = c;
            if (!m_busy) break;
        end
        st = 0; en_r = 0;
    endtask

    task automatic test_reset();
        int nd = 0;
        rst = 0; tick(); tick();
        checks++;
        if ({busy0, iv0, k0, ia0, ib0, bv0, ba0, bb0, bs0, bl0, dn0, busy2, iv2, k2, bv2, dn2} !== '0) begin
            errors++; $display("FAIL reset_state: u0 busy=%b iv=%b k=%0d bv=%b done=%b u2 busy=%b, all required 0",
                               busy0, iv0, k0, bv0, dn0, busy2);
        end
        rst = 1; sel = 0; st = 1; en_r = 1;
        for (int c = 1; c <= 6; c++) begin tick(); st = 0; nd += int'(dn0); end
        checks++;
        if (busy0 !== 1 || iv0 !== 1 || ia0 !== 3'd1 || ib0 !== 3'd3 || k0 !== 2'd2) begin
            errors++; $display("FAIL reset_pre: busy=%b iv=%b a=%0d b=%0d k=%0d, required 1 1 1 3 2",
                               busy0, iv0, ia0, ib0, k0);
        end
        rst = 0; tick(); nd += int'(dn0);
        checks++;
        if ({busy0, iv0, k0, ia0, ib0, bv0, ba0, bb0, bs0, bl0, dn0} !== '0) begin
            errors++; $display("FAIL reset_mid: busy=%b iv=%b a=%0d b=%0d k=%0d bv=%b ba=%0d bs=%0d, all required 0",
                               busy0, iv0, ia0, ib0, k0, bv0, ba0, bs0);
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL reset_no_done: %0d done pulses, required 0", nd); end
        en_r = 0; rst = 1; tick();
        checks++;
        if (busy0 !== 0 || dn0 !== 0) begin
            errors++; $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy0, dn0);
        end
    endtask

    task automatic test_sequence(input string nm, input bit s, input int gap, input int hs, input int hl, input bit spam);
        int lc, j, bj, nb, nd, dc, ec, be;
        run8(s, hs, hl, spam, lc);
        j = 0; bj = 0; nb = 0; nd = 0; dc = -1; be = 14 + 2 * gap + hl;
        for (int c = 1; c <= lc; c++) begin
            nb += int'(L[c].busy);
            if (L[c].dn) begin nd++; dc = c; end
            if (L[c].iv) begin
                checks++;
                ec = 1 + j + gap * (j / 4) + (j >= hs ? hl : 0);
                if (j >= 12) begin
                    errors++; $display("FAIL %s extra_issue: issue %0d at cycle %0d, required 12 issues", nm, j, c);
                end else if (c != ec || L[c].a !== 3'(ta[j]) || L[c].b !== 3'(tb[j]) || L[c].k !== 2'(tk[j])) begin
                    errors++; $display("FAIL %s issue%0d: cyc=%0d a=%0d b=%0d k=%0d, required cyc=%0d a=%0d b=%0d k=%0d",
                                       nm, j, c, L[c].a, L[c].b, L[c].k, ec, ta[j], tb[j], tk[j]);
                end
                j++;
            end else if (j > 0 && j < 12) begin
                checks++;
                if (L[c].a !== 3'(ta[j-1]) || L[c].b !== 3'(tb[j-1]) || L[c].k !== 2'(tk[j-1])) begin
                    errors++; $display("FAIL %s hold cyc%0d: a=%0d b=%0d k=%0d, required a=%0d b=%0d k=%0d",
                                       nm, c, L[c].a, L[c].b, L[c].k, ta[j-1], tb[j-1], tk[j-1]);
                end
            end
            if (L[c].bv) begin
                checks++;
                ec = 3 + bj + gap * (bj / 4) + (bj >= hs ? hl : 0);
                if (bj >= 12) begin
                    errors++; $display("FAIL %s extra_bf: bf %0d at cycle %0d, required 12", nm, bj, c);
                end else if (c != ec || L[c].ba !== 3'(ta[bj]) || L[c].bb !== 3'(tb[bj]) ||
                             L[c].bs !== 3'(bj / 4) || L[c].bl !== (bj % 4 == 3)) begin
                    errors++; $display("FAIL %s bf%0d: cyc=%0d a=%0d b=%0d stage=%0d last=%b, required cyc=%0d a=%0d b=%0d stage=%0d last=%b",
                                       nm, bj, c, L[c].ba, L[c].bb, L[c].bs, L[c].bl, ec, ta[bj], tb[bj], bj / 4, bj % 4 == 3);
                end
                bj++;
            end
        end
        checks++;
        if (j != 12 || bj != 12) begin
            errors++; $display("FAIL %s counts: issues=%0d bf=%0d, required 12 12", nm, j, bj);
        end
        checks++;
        if (nb != be) begin errors++; $display("FAIL %s busy_len: %0d cycles, required %0d", nm, nb, be); end
        checks++;
        if (nd != 1 || dc != be) begin
            errors++; $display("FAIL %s done: %0d pulses last at cycle %0d, required 1 at cycle %0d", nm, nd, dc, be);
        end
        checks++;
        if (L[lc].busy !== 0 || lc != be + 1) begin
            errors++; $display("FAIL %s busy_drop: busy=%b at cycle %0d, required 0 at cycle %0d", nm, L[lc].busy, lc, be + 1);
        end
    endtask

    task automatic test_alignment();
        int nbf = 0, nd = 0, nl = 0, kx, sp, cyc = 0;
        logic qv1 = 0, qv2 = 0;
        logic [11:0] qk1 = '0, qk2 = '0;
        st2 = 1; en2 = 1;
        for (int i = 1; i < 90000; i++) begin
            tick(); st2 = 0; cyc = i;
            checks++;
            if (bv2 !== qv2) begin
                errors++;
                if (errors < 20) $display("FAIL align_valid cyc%0d: bf_valid=%b, required %b", i, bv2, qv2);
            end
            if (bv2 === 1) begin
                sp = 1 << int'(bs2);
                kx = (int'(ba2) & (sp - 1)) << (12 - int'(bs2));
                checks++;
                if (kx != int'(qk2) || int'(bb2) != int'(ba2) + sp) begin
                    errors++;
                    if (errors < 20) $display("FAIL align_k cyc%0d: issued k=%0d bf_b=%0d, required k=%0d bf_b=%0d",
                                              i, qk2, bb2, kx, int'(ba2) + sp);
                end
                nbf++;
                nl += int'(bl2);
            end
            nd += int'(dn2);
            qv2 = qv1; qk2 = qk1; qv1 = iv2; qk1 = k2;
            en2 = $urandom_range(15) != 0;
            if (!busy2) break;
        end
        en2 = 0;
        checks++;
        if (busy2 !== 0) begin errors++; $display("FAIL align_timeout: busy=%b after %0d cycles, required 0", busy2, cyc); end
        checks++;
        if (nbf != 53248 || nl != 13) begin
            errors++; $display("FAIL align_counts: bf=%0d last=%0d, required 53248 13", nbf, nl);
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL align_done: %0d pulses, required 1", nd); end
    endtask

    initial begin
        test_reset();
        test_sequence("after_reset", 0, 0, 99, 0, 0);
        test_sequence("stage_gap", 1, 3, 99, 0, 0);
        test_sequence("stall", 0, 0, 5, 5, 0);
        test_sequence("start_ignored", 1, 3, 99, 0, 1);
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
